// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter onto a single FIFO write port
//
// Grants one requester at a time and forwards its beats to the FIFO
// until the packet ends (last) or MAX_BURST beats have been written.
// Each new grant costs one arbitration cycle in IDLE.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_req_valid[k]   requester k presents a beat
//   i_req_data       requester k data at [k*WIDTH +: WIDTH]
//   i_req_last[k]    final beat of requester k's packet
//   o_req_ready[k]   requester k's beat is accepted this cycle
//   o_fifo_data      FIFO write data (zero when no beat)
//   o_fifo_wr_en     FIFO write strobe
//   i_fifo_full      FIFO full flag
//   o_grant          registered one-hot grant, zero when none held
//   o_busy           high while a burst is in progress
module fifo_wr_arbiter #(
  parameter int WIDTH     = 16,
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [N_REQ-1:0]       i_req_valid,
  input  logic [N_REQ*WIDTH-1:0] i_req_data,
  input  logic [N_REQ-1:0]       i_req_last,
  output logic [N_REQ-1:0]       o_req_ready,
  output logic [WIDTH-1:0]       o_fifo_data,
  output logic                   o_fifo_wr_en,
  input  logic                   i_fifo_full,
  output logic [N_REQ-1:0]       o_grant,
  output logic                   o_busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BURST);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               pick_found;
  logic [IW-1:0]      pick_idx;
  logic [N_REQ-1:0]   pick_oh;
  logic               g_valid;
  logic               g_last;
  logic               beat;
  logic [CW-1:0]      cnt_inc;

  // grant_q is all-zero in IDLE, so these collapse to 0 there and
  // last/valid from non-granted requesters never leak through.
  assign g_valid = |(i_req_valid & grant_q);
  assign g_last  = |(i_req_last & grant_q);
  assign beat    = (state_q == S_BURST) && g_valid && !i_fifo_full;
  assign cnt_inc = cnt_q + CW'(1);

  // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
  always_comb begin : arb_pick
    int cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!pick_found && i_req_valid[IW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(cand);
      end
    end
    pick_oh = N_REQ'(1) << pick_idx;
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d = S_BURST;
          grant_d = pick_oh;
          gidx_d  = pick_idx;
          cnt_d   = '0;
        end
      end
      S_BURST: begin
        // A dropped valid or a full FIFO simply holds everything.
        if (beat) begin
          cnt_d = cnt_inc;
          if (g_last || (cnt_inc == CNT_MAX)) begin
            state_d  = S_IDLE;
            grant_d  = '0;
            rr_ptr_d = (gidx_q == LAST_IDX) ? '0 : gidx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    o_busy       = (state_q == S_BURST);
    o_grant      = grant_q;
    o_req_ready  = (o_busy && !i_fifo_full) ? grant_q : '0;
    o_fifo_wr_en = beat;
    o_fifo_data  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (beat && grant_q[k]) o_fifo_data = i_req_data[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed vector bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int W = 16;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   fifo_data;
  logic           fifo_wr_en;
  logic           fifo_full;
  logic [N-1:0]   grant;
  logic           busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.WIDTH(W), .N_REQ(N), .MAX_BURST(8)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .i_req_data   (req_data),
    .i_req_last   (req_last),
    .o_req_ready  (req_ready),
    .o_fifo_data  (fifo_data),
    .o_fifo_wr_en (fifo_wr_en),
    .i_fifo_full  (fifo_full),
    .o_grant      (grant),
    .o_busy       (busy)
  );

  wire [25:0] obs = {req_ready, fifo_wr_en, fifo_data, grant, busy};

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        full;
    logic [3:0]  e_ready;
    logic        e_wr;
    logic [15:0] e_data;
    logic [3:0]  e_grant;
    logic        e_busy;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(logic [3:0] v, logic [3:0] l, logic f, logic [3:0] r,
                              logic w, logic [15:0] d, logic [3:0] g, logic b);
    vec_t x;
    x.valid = v; x.last = l; x.full = f; x.e_ready = r;
    x.e_wr = w; x.e_data = d; x.e_grant = g; x.e_busy = b;
    return x;
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    req_data  = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [22:0] wr_pat;
    logic [12:0] bp_pat;
    logic [12:0] full_pat;
    int          beat_idx;
    int          data_err;
    int          rdy_err;
    int          writes;
    logic        busy_end;

    // ---------------- reset state ----------------
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    fifo_full = 1'b0;
    req_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    #1 check("reset_outputs", 64'(obs), 64'd0);
    @(posedge clk); #1;
    check("reset_held_after_edge", 64'(obs), 64'd0);

    // ---------------- vector table: fairness, wrap, hold, backpressure ----------------
    //                valid    last     f  ready    wr  data      grant    busy
    vecs[0]  = mk(4'b1111, 4'b1111, 0, 4'b0000, 0, 16'h0000, 4'b0000, 0);
    vecs[1]  = mk(4'b1111, 4'b1111, 0, 4'b0001, 1, 16'h1111, 4'b0001, 1);
    vecs[2]  = mk(4'b1111, 4'b1111, 0, 4'b0000, 0, 16'h0000, 4'b0000, 0);
    vecs[3]  = mk(4'b1111, 4'b1111, 0, 4'b0010, 1, 16'h2222, 4'b0010, 1);
    vecs[4]  = mk(4'b1111, 4'b1111, 0, 4'b0000, 0, 16'h0000, 4'b0000, 0);
    vecs[5]  = mk(4'b1111, 4'b1111, 0, 4'b0100, 1, 16'h3333, 4'b0100, 1);
    vecs[6]  = mk(4'b1111, 4'b1111, 0, 4'b0000, 0, 16'h0000, 4'b0000, 0);
    vecs[7]  = mk(4'b1111, 4'b1111, 0, 4'b1000, 1, 16'h4444, 4'b1000, 1);
    vecs[8]  = mk(4'b1111, 4'b1111, 0, 4'b0000, 0, 16'h0000, 4'b0000, 0);
    vecs[9]  = mk(4'b1111, 4'b1111, 0, 4'b0001, 1, 16'h1111, 4'b0001, 1);
    vecs[10] = mk(4'b0100, 4'b1111, 0, 4'b0000, 0, 16'h0000, 4'b0000, 0);
    vecs[11] = mk(4'b0100, 4'b1111, 0, 4'b0100, 1, 16'h3333, 4'b0100, 1);
    vecs[12] = mk(4'b1010, 4'b1111, 0, 4'b0000, 0, 16'h0000, 4'b0000, 0);
    vecs[13] = mk(4'b1010, 4'b1111, 0, 4'b1000, 1, 16'h4444, 4'b1000, 1);
    vecs[14] = mk(4'b1010, 4'b1111, 0, 4'b0000, 0, 16'h0000, 4'b0000, 0);
    vecs[15] = mk(4'b1010, 4'b1111, 0, 4'b0010, 1, 16'h2222, 4'b0010, 1);
    vecs[16] = mk(4'b0001, 4'b0000, 0, 4'b0000, 0, 16'h0000, 4'b0000, 0);
    vecs[17] = mk(4'b0001, 4'b1110, 0, 4'b0001, 1, 16'h1111, 4'b0001, 1);
    vecs[18] = mk(4'b0000, 4'b0000, 0, 4'b0001, 0, 16'h0000, 4'b0001, 1);
    vecs[19] = mk(4'b0001, 4'b0001, 1, 4'b0000, 0, 16'h0000, 4'b0001, 1);
    vecs[20] = mk(4'b0001, 4'b0001, 0, 4'b0001, 1, 16'h1111, 4'b0001, 1);
    vecs[21] = mk(4'b0000, 4'b0000, 0, 4'b0000, 0, 16'h0000, 4'b0000, 0);

    // release reset and run the table from rr_ptr = 0
    req_valid = '0;
    req_last  = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 22; i++) begin
      req_valid = vecs[i].valid;
      req_last  = vecs[i].last;
      fifo_full = vecs[i].full;
      @(negedge clk);
      check($sformatf("vec%0d", i), 64'(obs),
            64'({vecs[i].e_ready, vecs[i].e_wr, vecs[i].e_data, vecs[i].e_grant, vecs[i].e_busy}));
      @(posedge clk); #1;
    end

    // ---------------- burst cap: 20 beats on requester 2, no last ----------------
    do_reset();
    beat_idx  = 0;
    data_err  = 0;
    wr_pat    = '0;
    req_valid = 4'b0100;
    req_data[2*W +: W] = 16'h0A00;
    for (int c = 0; c < 23; c++) begin
      @(negedge clk);
      wr_pat[c] = fifo_wr_en;
      if (fifo_wr_en && fifo_data !== 16'(16'h0A00 + beat_idx)) data_err++;
      @(posedge clk); #1;
      if (wr_pat[c]) beat_idx++;
      if (beat_idx == 20) req_valid = '0;
      req_data[2*W +: W] = 16'(16'h0A00 + beat_idx);
    end
    check("cap_wr_pattern", 64'(wr_pat), 64'(23'b1111_0_11111111_0_11111111_0));
    check("cap_beats", 64'(beat_idx), 64'd20);
    check("cap_data_order_errs", 64'(data_err), 64'd0);
    @(negedge clk);
    check("cap_hold_after_valid_drop", 64'({busy, grant, fifo_wr_en}), 64'({1'b1, 4'b0100, 1'b0}));

    // ---------------- backpressure mid burst, cap still at 8 ----------------
    do_reset();
    beat_idx  = 0;
    data_err  = 0;
    rdy_err   = 0;
    bp_pat    = '0;
    full_pat  = 13'b0_000000_111_00_0;
    busy_end  = 1'b1;
    req_valid = 4'b0001;
    req_data[0 +: W] = 16'h0100;
    for (int c = 0; c < 13; c++) begin
      fifo_full = full_pat[c];
      @(negedge clk);
      bp_pat[c] = fifo_wr_en;
      if (fifo_full && req_ready !== 4'b0000) rdy_err++;
      if (fifo_wr_en && fifo_data !== 16'(16'h0100 + beat_idx)) data_err++;
      if (c == 12) busy_end = busy;
      @(posedge clk); #1;
      if (bp_pat[c]) beat_idx++;
      req_data[0 +: W] = 16'(16'h0100 + beat_idx);
    end
    check("bp_wr_pattern", 64'(bp_pat), 64'(13'b0_111111_000_11_0));
    check("bp_ready_low_while_full", 64'(rdy_err), 64'd0);
    check("bp_data_order_errs", 64'(data_err), 64'd0);
    check("bp_idle_after_8_beats", 64'(busy_end), 64'd0);

    // ---------------- reset mid burst ----------------
    do_reset();
    req_valid = 4'b0100;
    req_data  = {16'h4444, 16'h3333, 16'h2222, 16'h5A5A};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    check("rst_mid_busy_before", 64'({busy, grant}), 64'({1'b1, 4'b0100}));
    rst_n = 1'b0;
    #1 check("rst_mid_immediate", 64'({fifo_wr_en, grant, busy, req_ready}), 64'd0);
    req_valid = 4'b0101;
    @(posedge clk); #1;
    check("rst_mid_held", 64'(obs), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_restart_grant0", 64'({grant, fifo_wr_en, fifo_data}), 64'({4'b0001, 1'b1, 16'h5A5A}));

    // ---------------- single-beat packet on requester 1 ----------------
    do_reset();
    writes    = 0;
    req_valid = 4'b0010;
    req_last  = 4'b0010;
    req_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    @(negedge clk); if (fifo_wr_en) writes++;
    @(posedge clk); #1;
    @(negedge clk); if (fifo_wr_en) writes++;
    check("single_data", 64'(fifo_data), 64'h2222);
    @(posedge clk); #1;
    req_valid = '0;
    req_last  = '0;
    @(negedge clk); if (fifo_wr_en) writes++;
    check("single_idle_after", 64'(busy), 64'd0);
    check("single_write_count", 64'(writes), 64'd1);
    @(posedge clk); #1;
    req_valid = 4'b1111;
    @(posedge clk); #1;
    @(negedge clk);
    check("single_rr_next_is_2", 64'(grant), 64'(4'b0100));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter WIDTH, default 16: data width of every requester and of the FIFO write bus.
REQ-002 Parameter N_REQ, default 4: number of requesters; legal range 2..8.
REQ-003 Parameter MAX_BURST, default 8: maximum beats per grant; legal range 1..256.
REQ-004 Port i_clk, input, 1: single clock; all state is updated on its rising edge.
REQ-005 Port i_rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port i_req_valid, input, N_REQ: bit k set means requester k presents a beat.
REQ-007 Port i_req_data, input, N_REQ*WIDTH: requester k data occupies bits [k*WIDTH +: WIDTH].
REQ-008 Port i_req_last, input, N_REQ: bit k set marks the final beat of requester k's packet.
REQ-009 Port o_req_ready, output, N_REQ: bit k set means the current beat of requester k is accepted this cycle.
REQ-010 Port o_fifo_data, output, WIDTH: data to the FIFO write port.
REQ-011 Port o_fifo_wr_en, output, 1: FIFO write strobe.
REQ-012 Port i_fifo_full, input, 1: FIFO full flag.
REQ-013 Port o_grant, output, N_REQ: one-hot registered grant; all-zero when no grant is held.
REQ-014 Port o_busy, output, 1: high while in state BURST.

Function
REQ-015 The block SHALL have two states: IDLE and BURST.
REQ-016 In IDLE with any i_req_valid bit set, the block SHALL select the first set bit searching upward, with wrap, from index rr_ptr, SHALL load o_grant with that one-hot value and SHALL enter BURST on the next edge.
REQ-017 In IDLE, o_req_ready and o_fifo_wr_en SHALL be 0, so arbitration costs exactly one cycle per grant.
REQ-018 In BURST with granted index g, o_req_ready[g] SHALL equal !i_fifo_full; all other ready bits SHALL be 0.
REQ-019 A beat occurs when i_req_valid[g] && o_req_ready[g]; o_fifo_wr_en SHALL equal the beat condition combinationally, and o_fifo_data SHALL equal requester g's data with zero added latency.
REQ-020 When i_fifo_full is high, no beat SHALL occur; grant and beat count SHALL hold.
REQ-021 A beat counter of width $clog2(MAX_BURST+1) SHALL clear on entry to BURST and increment on each beat.
REQ-022 The block SHALL return to IDLE after a beat with i_req_last[g] set, or after the beat that brings the count to MAX_BURST, whichever comes first. On that edge, o_grant SHALL clear and rr_ptr SHALL become (g+1) mod N_REQ.
REQ-023 If i_req_valid[g] drops mid-burst, the grant SHALL be held without a timeout.
REQ-024 When not in a beat, o_fifo_data SHALL be 0.
REQ-025 i_req_last on a non-granted requester SHALL be ignored.

Reset
REQ-026 While i_rst_n is low, the block SHALL asynchronously force state IDLE, o_grant 0, rr_ptr 0 and beat count 0.
REQ-027 While i_rst_n is low, o_req_ready, o_fifo_wr_en, o_fifo_data and o_busy SHALL read 0.
REQ-028 Reset asserted mid-burst SHALL abandon the burst with no further write. After release, arbitration SHALL restart from requester 0.

Verification
REQ-029 Fairness: all 4 requesters continuously valid, last set on every beat, FIFO never full -> grants 0,1,2,3,0 with one IDLE cycle between each, so each requester gets one write per 2 cycles of its own turn.
REQ-030 Burst cap: MAX_BURST=8, requester 2 streams 20 beats with last never set, requester 3 idle -> exactly 8 writes, 1 IDLE cycle, 8 writes, 1 IDLE cycle, 4 writes.
REQ-031 Backpressure: i_fifo_full high for 3 cycles mid-burst -> o_req_ready[g]=0 and o_fifo_wr_en=0 for those 3 cycles; data order is preserved and the beat count is unchanged.
REQ-032 Wrap: rr_ptr=3, only requesters 1 and 3 valid -> requester 3 is granted first, then requester 1.
REQ-033 Reset mid-burst: i_rst_n pulled low after beat 2 of 5 -> o_fifo_wr_en and o_grant are 0 within the same cycle; after release with requesters 0 and 2 valid, requester 0 is granted.
REQ-034 Single-beat packet: one valid beat with last set on requester 1 -> exactly one write, then IDLE, and rr_ptr becomes 2.
